// File: rtl/rnbip_mem_pkg.sv
// Shared op codes, FSM encoding and stack defaults for the data-memory sequencer.
// The stack bounds check is built only when SP_BOUNDS_CHECK_EN is defined.
package rnbip_mem_pkg;

    localparam logic [2:0] OP_NOP   = 3'd0;
    localparam logic [2:0] OP_PUSH  = 3'd1;
    localparam logic [2:0] OP_POP   = 3'd2;
    localparam logic [2:0] OP_CALL  = 3'd3;
    localparam logic [2:0] OP_RET   = 3'd4;
    localparam logic [2:0] OP_LOAD  = 3'd5;
    localparam logic [2:0] OP_STORE = 3'd6;

    localparam logic [7:0] SP_RESET_DEFAULT    = 8'hFF;
    localparam logic [7:0] STACK_LIMIT_DEFAULT = 8'h80;

    localparam logic [1:0] FAULT_OVF = 2'b01;
    localparam logic [1:0] FAULT_UNF = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE,
        S_DEC,
        S_WRITE,
        S_READ,
        S_ACCESS,
        S_DONE
    } state_t;

    function automatic logic op_is_active(input logic [2:0] o);
        return (o >= OP_PUSH) && (o <= OP_STORE);
    endfunction

    function automatic logic op_is_stack_wr(input logic [2:0] o);
        return (o == OP_PUSH) || (o == OP_CALL);
    endfunction

    function automatic logic op_is_stack_rd(input logic [2:0] o);
        return (o == OP_POP) || (o == OP_RET);
    endfunction

endpackage

// File: rtl/stack_ptr_reg.sv
// Downward-growing 8-bit stack pointer with empty/full flags.
// Arithmetic wraps modulo 256; simultaneous inc and dec cancel.
module stack_ptr_reg
    import rnbip_mem_pkg::*;
#(
    parameter logic [7:0] SP_RESET    = SP_RESET_DEFAULT,
    parameter logic [7:0] STACK_LIMIT = STACK_LIMIT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       inc,
    input  logic       dec,
    output logic [7:0] sp,
    output logic       is_empty,
    output logic       is_full
);

    always_ff @(posedge clk) begin
        if (reset) begin
            sp <= SP_RESET;
        end else if (inc && !dec) begin
            sp <= sp + 8'd1;
        end else if (dec && !inc) begin
            sp <= sp - 8'd1;
        end
    end

    assign is_empty = (sp == SP_RESET);
    assign is_full  = (sp == STACK_LIMIT);

endmodule

// File: rtl/stack_mem_sequencer.sv
// Sequences PUSH/POP/CALL/RET/LOAD/STORE onto the 256x8 data memory.
// Define SP_BOUNDS_CHECK_EN to trap stack overflow/underflow into fault.
module stack_mem_sequencer
    import rnbip_mem_pkg::*;
#(
    parameter logic [7:0] SP_RESET    = SP_RESET_DEFAULT,
    parameter logic [7:0] STACK_LIMIT = STACK_LIMIT_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       op_valid,
    input  logic [2:0] op,
    output logic       op_ready,
    input  logic [7:0] mem_rdata,
    output logic [7:0] sp_out,
    output logic       mem_addr_sel_sp,
    output logic       mem_data_sel_rn,
    output logic       mem_wr,
    output logic [7:0] rd_data,
    output logic       rd_load,
    output logic [7:0] pc_target,
    output logic       pc_load,
    output logic       done,
    output logic [1:0] fault
);

    state_t     state;
    logic [2:0] cur_op;
    logic       wr_q;
    logic [1:0] fault_q;
    logic       accept;
    logic       sp_inc;
    logic       sp_dec;
    logic       is_empty;
    logic       is_full;
    logic       ovf;
    logic       unf;

`ifdef SP_BOUNDS_CHECK_EN
    assign ovf = is_full;
    assign unf = is_empty;
`else
    logic unused_flags;
    assign unused_flags = is_full | is_empty;
    assign ovf = 1'b0;
    assign unf = 1'b0;
`endif

    assign op_ready = (state == S_IDLE);
    assign accept   = op_valid && op_ready && op_is_active(op);
    assign sp_dec   = accept && op_is_stack_wr(op) && !ovf;
    assign sp_inc   = (state == S_READ);

    stack_ptr_reg #(
        .SP_RESET    (SP_RESET),
        .STACK_LIMIT (STACK_LIMIT)
    ) u_sp (
        .clk      (clk),
        .reset    (reset),
        .inc      (sp_inc),
        .dec      (sp_dec),
        .sp       (sp_out),
        .is_empty (is_empty),
        .is_full  (is_full)
    );

    // A write still pending in the reset cycle must never reach the memory.
    assign mem_wr = wr_q && !reset;
    assign fault  = fault_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state           <= S_IDLE;
            cur_op          <= OP_NOP;
            wr_q            <= 1'b0;
            mem_addr_sel_sp <= 1'b0;
            mem_data_sel_rn <= 1'b0;
            rd_data         <= 8'h00;
            rd_load         <= 1'b0;
            pc_target       <= 8'h00;
            pc_load         <= 1'b0;
            done            <= 1'b0;
            fault_q         <= 2'b00;
        end else begin
            wr_q            <= 1'b0;
            mem_addr_sel_sp <= 1'b0;
            mem_data_sel_rn <= 1'b0;
            rd_load         <= 1'b0;
            pc_load         <= 1'b0;
            done            <= 1'b0;
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        cur_op  <= op;
                        fault_q <= 2'b00;
                        unique case (1'b1)
                            op_is_stack_wr(op): begin
                                if (ovf) begin
                                    fault_q <= FAULT_OVF;
                                    done    <= 1'b1;
                                    state   <= S_DONE;
                                end else begin
                                    state <= S_DEC;
                                end
                            end
                            op_is_stack_rd(op): begin
                                if (unf) begin
                                    fault_q <= FAULT_UNF;
                                    done    <= 1'b1;
                                    state   <= S_DONE;
                                end else begin
                                    mem_addr_sel_sp <= 1'b1;
                                    state           <= S_READ;
                                end
                            end
                            default: begin
                                wr_q            <= (op == OP_STORE);
                                mem_data_sel_rn <= (op == OP_STORE);
                                state           <= S_ACCESS;
                            end
                        endcase
                    end
                end
                S_DEC: begin
                    wr_q            <= 1'b1;
                    mem_addr_sel_sp <= 1'b1;
                    mem_data_sel_rn <= (cur_op == OP_PUSH);
                    state           <= S_WRITE;
                end
                S_WRITE: begin
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_READ: begin
                    if (cur_op == OP_POP) begin
                        rd_data <= mem_rdata;
                        rd_load <= 1'b1;
                    end else begin
                        pc_target <= mem_rdata;
                        pc_load   <= 1'b1;
                    end
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_ACCESS: begin
                    if (cur_op == OP_LOAD) begin
                        rd_data <= mem_rdata;
                        rd_load <= 1'b1;
                    end
                    done  <= 1'b1;
                    state <= S_DONE;
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_stack_mem_sequencer.sv
// Bench for stack_mem_sequencer: directed literal checks plus random ops
// compared every cycle against a stack/memory model of the sequencer.
module tb_stack_mem_sequencer;
    import rnbip_mem_pkg::*;

`ifdef SP_BOUNDS_CHECK_EN
    localparam bit BOUNDS = 1'b1;
`else
    localparam bit BOUNDS = 1'b0;
`endif
    localparam logic [7:0] SPR = 8'hFF;
    localparam logic [7:0] LIM = 8'h80;

    logic       clk = 1'b0;
    logic       reset;
    logic       op_valid;
    logic [2:0] op;
    logic       op_ready;
    logic [7:0] mem_rdata;
    logic [7:0] sp_out;
    logic       sel_sp;
    logic       sel_rn;
    logic       mem_wr;
    logic [7:0] rd_data;
    logic       rd_load;
    logic [7:0] pc_target;
    logic       pc_load;
    logic       done;
    logic [1:0] fault;

    logic [7:0] r0;
    logic [7:0] rn;
    logic [7:0] npc;
    logic [7:0] mem [256];
    logic [7:0] addr;
    logic [7:0] wdata;

    int errors = 0;
    int checks = 0;

    stack_mem_sequencer dut (
        .clk             (clk),
        .reset           (reset),
        .op_valid        (op_valid),
        .op              (op),
        .op_ready        (op_ready),
        .mem_rdata       (mem_rdata),
        .sp_out          (sp_out),
        .mem_addr_sel_sp (sel_sp),
        .mem_data_sel_rn (sel_rn),
        .mem_wr          (mem_wr),
        .rd_data         (rd_data),
        .rd_load         (rd_load),
        .pc_target       (pc_target),
        .pc_load         (pc_load),
        .done            (done),
        .fault           (fault)
    );

    always #5 clk = ~clk;

    assign addr      = sel_sp ? sp_out : r0;
    assign wdata     = sel_rn ? rn : npc;
    assign mem_rdata = mem[addr];

    // Environment data memory driven by the DUT.
    initial begin
        for (int i = 0; i < 256; i++) mem[i] = 8'(i * 3 + 1);
        forever begin
            @(posedge clk);
            if (mem_wr) mem[addr] <= wdata;
        end
    end

    typedef struct {
        bit         ready;
        logic [7:0] sp;
        bit         wr;
        bit         ssp;
        bit         srn;
        bit         dn;
        bit         rdl;
        bit         pcl;
        logic [7:0] rdd;
        logic [7:0] pct;
        logic [1:0] flt;
        bit         wen;
        logic [7:0] wa;
        logic [7:0] wd;
    } exp_t;

    exp_t       q[$];
    logic [7:0] mm [256];
    logic [7:0] m_sp;
    logic [7:0] m_rd;
    logic [7:0] m_pc;
    logic [1:0] m_flt;
    bit         cur_ready = 1'b0;

    task automatic chk(input string nm, input logic [7:0] act,
                       input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %02h expected %02h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic push_e(input bit ready, input bit wr, input bit ssp,
                          input bit srn, input bit dn, input bit rdl,
                          input bit pcl, input bit wen,
                          input logic [7:0] wa, input logic [7:0] wd);
        exp_t e;
        e.ready = ready; e.sp = m_sp;
        e.wr = wr; e.ssp = ssp; e.srn = srn;
        e.dn = dn; e.rdl = rdl; e.pcl = pcl;
        e.rdd = m_rd; e.pct = m_pc; e.flt = m_flt;
        e.wen = wen; e.wa = wa; e.wd = wd;
        q.push_back(e);
    endtask

    // One accepted op expands into the outputs of each cycle it occupies.
    task automatic model_op(input logic [2:0] o);
        logic [7:0] v;
        m_flt = 2'b00;
        if (o == OP_PUSH || o == OP_CALL) begin
            if (BOUNDS && m_sp == LIM) begin
                m_flt = 2'b01;
                push_e(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
            end else begin
                m_sp = m_sp - 8'd1;
                push_e(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
                push_e(0, 1, 1, o == OP_PUSH, 0, 0, 0, 1, m_sp,
                       (o == OP_PUSH) ? rn : npc);
                push_e(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
            end
        end else if (o == OP_POP || o == OP_RET) begin
            if (BOUNDS && m_sp == SPR) begin
                m_flt = 2'b10;
                push_e(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
            end else begin
                v = mm[m_sp];
                push_e(0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
                m_sp = m_sp + 8'd1;
                if (o == OP_POP) m_rd = v;
                else m_pc = v;
                push_e(0, 0, 0, 0, 1, o == OP_POP, o == OP_RET, 0, 0, 0);
            end
        end else if (o == OP_LOAD) begin
            push_e(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            m_rd = mm[r0];
            push_e(0, 0, 0, 0, 1, 1, 0, 0, 0, 0);
        end else begin
            push_e(0, 1, 0, 1, 0, 0, 0, 1, r0, rn);
            push_e(0, 0, 0, 0, 1, 0, 0, 0, 0, 0);
        end
    endtask

    // Reference model: advances on each rising edge.
    initial begin
        for (int i = 0; i < 256; i++) mm[i] = 8'(i * 3 + 1);
        forever begin
            @(posedge clk);
            if (reset) begin
                q.delete();
                m_sp = SPR; m_rd = 8'h00; m_pc = 8'h00; m_flt = 2'b00;
                push_e(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            end else if (q.size() == 0) begin
                if (cur_ready && op_valid && op >= OP_PUSH && op <= OP_STORE)
                    model_op(op);
                else
                    push_e(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
            end
        end
    end

    // Compare process: every cycle, mid-cycle.
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() == 0) begin
                chk("model_queue_empty", 8'd1, 8'd0);
            end else begin
                e = q.pop_front();
                cur_ready = e.ready;
                chk("op_ready", 8'(op_ready), 8'(e.ready));
                chk("sp_out", sp_out, e.sp);
                chk("mem_wr", 8'(mem_wr), 8'(e.wr && !reset));
                chk("sel_sp", 8'(sel_sp), 8'(e.ssp));
                chk("sel_rn", 8'(sel_rn), 8'(e.srn));
                chk("done", 8'(done), 8'(e.dn));
                chk("rd_load", 8'(rd_load), 8'(e.rdl));
                chk("pc_load", 8'(pc_load), 8'(e.pcl));
                chk("rd_data", rd_data, e.rdd);
                chk("pc_target", pc_target, e.pct);
                chk("fault", 8'(fault), 8'(e.flt));
                if (e.wen && !reset) mm[e.wa] = e.wd;
            end
        end
    end

    task automatic skip(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    // Called one step after a rising edge with the DUT idle.
    task automatic issue(input logic [2:0] o, input logic [7:0] a,
                         input logic [7:0] b, input logic [7:0] c);
        op_valid = 1'b1; op = o; r0 = a; rn = b; npc = c;
        @(posedge clk);
        #1;
        op_valid = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        skip(1);
        reset = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1; op_valid = 1'b0; op = OP_NOP;
        r0 = 8'h00; rn = 8'h00; npc = 8'h00;
        skip(2);
        reset = 1'b0;
        skip(1);
        @(negedge clk);
        chk("reset_sp", sp_out, 8'hFF);
        chk("reset_ready", 8'(op_ready), 8'h01);
        chk("reset_fault", 8'(fault), 8'h00);
        skip(1);

        issue(OP_PUSH, 8'h00, 8'hA5, 8'h00);
        @(negedge clk); chk("push_sp", sp_out, 8'hFE);
        @(negedge clk); chk("push_wr", 8'({mem_wr, sel_sp, sel_rn}), 8'h07);
        @(negedge clk); chk("push_done", 8'(done), 8'h01);
        skip(1);
        chk("push_mem", mem[8'hFE], 8'hA5);
        do_reset();

        issue(OP_CALL, 8'h00, 8'h00, 8'h42);
        skip(3);
        chk("call_mem", mem[8'hFE], 8'h42);
        issue(OP_RET, 8'h00, 8'h00, 8'h00);
        @(negedge clk);
        @(negedge clk);
        chk("ret_pc_load", 8'(pc_load), 8'h01);
        chk("ret_pc_target", pc_target, 8'h42);
        chk("ret_sp", sp_out, 8'hFF);
        skip(1);

        issue(OP_STORE, 8'h10, 8'h3C, 8'h00);
        skip(2);
        chk("store_mem", mem[8'h10], 8'h3C);
        issue(OP_LOAD, 8'h10, 8'h00, 8'h00);
        @(negedge clk); chk("load_sel_sp", 8'(sel_sp), 8'h00);
        @(negedge clk);
        chk("load_rd_load", 8'(rd_load), 8'h01);
        chk("load_rd_data", rd_data, 8'h3C);
        chk("load_sp", sp_out, 8'hFF);
        skip(1);

        do_reset();
        issue(OP_POP, 8'h00, 8'h00, 8'h00);
`ifdef SP_BOUNDS_CHECK_EN
        @(negedge clk);
        chk("upop_fault", 8'(fault), 8'h02);
        chk("upop_rd_load", 8'(rd_load), 8'h00);
        chk("upop_sp", sp_out, 8'hFF);
`else
        @(negedge clk);
        @(negedge clk);
        chk("wpop_sp", sp_out, 8'h00);
        chk("wpop_fault", 8'(fault), 8'h00);
`endif
        skip(1);

        do_reset();
        for (int i = 0; i < 127; i++) begin
            issue(OP_PUSH, 8'h00, 8'(i), 8'h00);
            skip(3);
        end
        chk("fill_sp", sp_out, 8'h80);
        issue(OP_PUSH, 8'h00, 8'hEE, 8'h00);
`ifdef SP_BOUNDS_CHECK_EN
        @(negedge clk);
        chk("ovf_fault", 8'(fault), 8'h01);
        chk("ovf_sp", sp_out, 8'h80);
        chk("ovf_wr", 8'(mem_wr), 8'h00);
        skip(1);
`else
        skip(3);
        chk("wpush_sp", sp_out, 8'h7F);
        chk("wpush_fault", 8'(fault), 8'h00);
`endif

        do_reset();
        issue(OP_PUSH, 8'h00, 8'h55, 8'h00);
        reset = 1'b1;
        @(negedge clk); chk("rst_dec_wr", 8'(mem_wr), 8'h00);
        skip(1);
        reset = 1'b0;
        @(negedge clk);
        chk("rst_dec_sp", sp_out, 8'hFF);
        chk("rst_dec_ready", 8'(op_ready), 8'h01);
        skip(1);

        op_valid = 1'b1; op = OP_PUSH; rn = 8'h77;
        for (int k = 0; k < 8; k++) begin
            @(negedge clk);
            chk("held_ready", 8'(op_ready), 8'((k % 4) == 0));
        end
        skip(1);
        op_valid = 1'b0;
        @(negedge clk); chk("held_sp", sp_out, 8'hFD);
        skip(1);

        do_reset();
        repeat (3000) begin
            reset    = ($urandom_range(0, 99) == 0);
            op_valid = ($urandom_range(0, 99) < 70);
            op       = 3'($urandom_range(0, 7));
            if (q.size() <= 1) begin
                r0  = $urandom_range(0, 1) ? 8'($urandom_range(240, 255))
                                           : 8'($urandom_range(0, 15));
                rn  = 8'($urandom);
                npc = 8'($urandom);
            end
            skip(1);
        end
        op_valid = 1'b0;
        reset = 1'b0;
        skip(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/stack_mem_sequencer.md
Name: stack_mem_sequencer

Overview:
- Upstream control stage for the 8-bit processor's 256x8 data memory.
- Accepts one memory/stack operation at a time: PUSH, POP, CALL, RET, LOAD or STORE.
- Owns the stack pointer (SP) and drives the memory's address-select, data-select and write-enable lines cycle by cycle.
- Captures read data, and hands return addresses to the PC logic.

Parameters:
- SP_RESET, 8'hFF: SP value after reset; the stack is empty when SP equals this value; the stack grows downward.
- STACK_LIMIT, 8'h80: lowest legal SP; the stack is full when SP equals this value.

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  synchronous, active-high reset
- op_valid  in  1  operation request
- op  in  3  0 NOP, 1 PUSH, 2 POP, 3 CALL, 4 RET, 5 LOAD, 6 STORE, 7 reserved (treated as NOP)
- op_ready  out  1  high only in IDLE
- mem_rdata  in  8  combinational read data from the data memory
- sp_out  out  8  current SP, to the memory's SP address input
- mem_addr_sel_sp  out  1  1 = memory address is SP; 0 = memory address is R0
- mem_data_sel_rn  out  1  1 = write data is RN; 0 = write data is NPC
- mem_wr  out  1  memory write enable
- rd_data  out  8  registered result of POP/LOAD
- rd_load  out  1  one-cycle strobe; rd_data is valid
- pc_target  out  8  registered return address from RET
- pc_load  out  1  one-cycle strobe; pc_target is valid
- done  out  1  one-cycle completion pulse
- fault  out  2  bit0 overflow, bit1 underflow; sticky until next accepted op

Behaviour:
- Reset values:
  - sp_out = SP_RESET; state = IDLE; op_ready = 1.
  - All strobes, mem_wr, select lines, rd_data, pc_target and fault are 0.
- Reset mid-operation aborts the operation; no memory write is issued on the reset cycle.
- Handshake:
  - An op is accepted on the rising edge where op_valid && op_ready.
  - NOP and code 7 are accepted but ignored: no done, state stays IDLE.
  - Accepting a non-NOP op clears fault.
- States: IDLE, DEC, WRITE, READ, ACCESS, DONE.
- PUSH / CALL:
  - IDLE -> DEC: SP <= SP-1.
  - DEC -> WRITE: mem_wr=1, mem_addr_sel_sp=1; mem_data_sel_rn=1 for PUSH, 0 for CALL (stores NPC).
  - WRITE -> DONE.
  - done is high 3 cycles after acceptance.
- POP / RET:
  - IDLE -> READ: mem_addr_sel_sp=1, mem_rdata sampled at the end of this cycle, SP <= SP+1.
  - READ -> DONE.
  - In DONE: POP drives rd_data with rd_load=1; RET drives pc_target with pc_load=1.
- LOAD / STORE:
  - IDLE -> ACCESS: mem_addr_sel_sp=0.
  - LOAD samples mem_rdata; STORE asserts mem_wr=1 with mem_data_sel_rn=1.
  - ACCESS -> DONE. LOAD pulses rd_load in DONE.
- DONE: done=1, op_ready=0, then -> IDLE.
- Peak rate: one op per 3 cycles (1-cycle ops) or per 4 cycles (PUSH/CALL).
- Outside the active states above, mem_wr = 0 and both select lines = 0.
- SP arithmetic is 8-bit modulo 256.

Optional Feature:
- Macro: SP_BOUNDS_CHECK_EN.
- Defined:
  - PUSH/CALL when SP==STACK_LIMIT: no SP change, no write, fault[0]=1, straight to DONE.
  - POP/RET when SP==SP_RESET: no SP change, no strobe, fault[1]=1, straight to DONE.
- Undefined: no checks; fault is tied to 0 and SP wraps freely (8'h00-1 = 8'hFF).

Decomposition:
- Package rnbip_mem_pkg holds:
  - the op-code localparams (OP_NOP..OP_STORE);
  - the state encoding;
  - the default SP_RESET and STACK_LIMIT.
- One sub-module: stack_ptr_reg.
  - Inputs: clk, reset, inc, dec.
  - Outputs: SP, is_empty, is_full.
  - The FSM stays in the top-level module.

Test Plan:
- Reset, then PUSH with RN=8'hA5 -> sp_out 8'hFE at T+1; mem_wr=1, sel_sp=1, sel_rn=1 at T+2; done at T+3; mem[8'hFE]=8'hA5.
- CALL with NPC=8'h42, then RET -> mem[8'hFE]=8'h42; RET gives pc_load=1, pc_target=8'h42 at acceptance+2; sp_out back to 8'hFF.
- STORE with R0=8'h10, RN=8'h3C, then LOAD R0=8'h10 -> LOAD gives rd_load=1, rd_data=8'h3C; sel_sp=0 throughout; SP unchanged at 8'hFF.
- With SP_BOUNDS_CHECK_EN, POP from reset -> fault=2'b10, no rd_load, SP=8'hFF. Push 127 times, then one more PUSH -> fault=2'b01, SP stays 8'h80.
- Without the macro, POP from reset -> SP=8'h00, fault=0.
- Assert reset during DEC of a PUSH -> no mem_wr that cycle; next cycle sp_out=SP_RESET, op_ready=1; op_valid held high during a busy op is not accepted until IDLE.
